mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Arbiter/sequencer sharing the single byte-wide RAM port between instruction fetch (IF) and
//  the MEM stage (loads/stores). Grants one requester at a time, splits each 1/2/4-byte access
//  into byte transfers, assembles/disassembles little-endian words, and raises per-port stall
//  requests toward the pipeline controller until the access completes.
// PARAMETERS
//  RAM_AW   17   RAM byte-address width; ram_addr = (req addr + byte index) mod 2^RAM_AW
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  if_req       in   1       IF wants a 4-byte fetch; held stable until if_done or if_cancel
//  if_addr      in   32      fetch address (pc)
//  if_cancel    in   1       branch taken: abort in-flight fetch
//  if_data      out  32      fetched instruction, valid while if_done=1
//  if_done      out  1       one-cycle fetch-complete pulse
//  stallreq_if  out  1       if_req & ~if_done (combinational)
//  mem_req      in   1       MEM-stage access request; held stable until mem_done
//  mem_we       in   1       1 = store, 0 = load
//  mem_sel      in   2       0 byte, 1 half, 2 word, 3 treated as word
//  mem_addr     in   32      data address
//  mem_wdata    in   32      store data, byte k = bits [8k+7:8k]
//  mem_rdata    out  32      load data, zero-extended (MEM stage sign-extends); valid while mem_done
//  mem_done     out  1       one-cycle access-complete pulse
//  stallreq_mem out  1       mem_req & ~mem_done (combinational)
//  ram_addr     out  RAM_AW  RAM byte address
//  ram_we       out  1       RAM write strobe
//  ram_wdata    out  8       RAM write byte
//  ram_rdata    in   8       RAM read byte, valid one cycle after ram_addr presented (ram_we=0)
// BEHAVIOUR
//  Reset: state IDLE, cnt 0; ram_we 0, ram_addr 0, ram_wdata 0, if_done 0, mem_done 0,
//   if_data 0, mem_rdata 0. Reset mid-access abandons it; no done pulse, no further RAM writes.
//  States: IDLE -> BUSY -> DONE -> IDLE. N = bytes of access (1/2/4; fetch always 4).
//  IDLE: mem_req has fixed priority over if_req (older instruction). On grant latch owner,
//   addr, we, N, wdata; cnt<=0; go BUSY. No request: stay IDLE, ram_we 0.
//  BUSY read: cnt runs 0..N (N+1 cycles). cnt<N: ram_addr=base+cnt. cnt>=1: capture ram_rdata
//   into byte cnt-1 of data register. cnt==N -> DONE.
//  BUSY write: cnt runs 0..N-1 (N cycles), ram_we=1, ram_addr=base+cnt, ram_wdata=byte cnt.
//   cnt==N-1 -> DONE.
//  DONE: assert owner's done for exactly one cycle with data register on if_data/mem_rdata
//   (unused upper bytes 0); next state IDLE. A new request may be granted in that IDLE cycle.
//  Latency grant->done: read N+2 cycles (word 6, byte 3); write N+1 (word 5, byte 2).
//  if_cancel while owner=IF in BUSY/DONE: next state IDLE, if_done suppressed; data discarded.
//   if_cancel in IDLE blocks an IF grant that cycle. if_cancel ignored when owner=MEM.
//  Simultaneous if_req & mem_req in IDLE: MEM granted, IF keeps stalling until served.
//  Address wrap: base+cnt truncated to RAM_AW bits (0x1FFFF+1 -> 0x00000 at RAM_AW=17).
//  Requests arriving during BUSY/DONE are not sampled; requester keeps stallreq asserted.
//  Byte order little-endian: address base+k <-> bits [8k+7:8k]. No misalignment check.
// TESTING
//  1 Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,50,00 -> ram_addr 0x100..0x103 in
//    cycles 1-4, if_done=1 at cycle 6 with if_data=0x00500513, stallreq_if 1 until then.
//  2 Store word: mem_req, mem_we=1, sel=2, addr=0x200, wdata=0xDEADBEEF -> ram_we 4 cycles with
//    bytes EF,BE,AD,DE at 0x200..0x203; mem_done at cycle 5; no RAM write afterwards.
//  3 Priority: if_req and mem_req (load byte @0x10, RAM=0x80) same cycle -> MEM served first,
//    mem_rdata=0x00000080 at cycle 3; IF granted cycle 4, if_done cycle 10.
//  4 Cancel: fetch started, if_cancel at cycle 3 -> IDLE next cycle, no if_done, new if_req
//    for 0x200 then completes normally.
//  5 Wrap: load half at addr 0x1FFFF (RAM_AW=17) -> ram_addr 0x1FFFF then 0x00000, data from both.
//  6 Reset: rst_n low mid store (cycle 2) -> ram_we 0 immediately, all outputs reset values.

Source files
------------

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage. One requester is granted at a time (MEM first), every 1/2/4-byte
// access is split into byte transfers, little-endian words are assembled or
// disassembled, and each port stalls the pipeline until its access is done.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr/if_cancel        4-byte fetch request, address, abort
//   if_data/if_done/stallreq_if     fetch result, done pulse, stall request
//   mem_req/mem_we/mem_sel          data access request, store flag, size
//   mem_addr/mem_wdata              data address, store data
//   mem_rdata/mem_done/stallreq_mem load result (zero-extended), done, stall
//   ram_addr/ram_we/ram_wdata       RAM byte address, write strobe, byte
//   ram_rdata                       RAM read byte, one cycle after address
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_cancel,
    output logic [31:0]       if_data,
    output logic              if_done,
    output logic              stallreq_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stallreq_mem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [2:0]          cnt_r, cnt_s;
    logic                own_mem_r, own_mem_s;
    logic                we_r, we_s;
    logic [2:0]          len_r, len_s;
    logic [RAM_AW-1:0]   base_r, base_s;
    logic [31:0]         wdata_r, wdata_s;
    logic [31:0]         data_r, data_s;
    logic [RAM_AW-1:0]   ram_addr_s;
    logic                ram_we_s;
    logic [7:0]          ram_wdata_s;
    logic [2:0]          cnt_inc_s;
    logic [2:0]          cnt_dec_s;
    logic                done_phase_s;
    logic                unused_s;

    // Byte count of an access; size code 3 behaves as a word.
    function automatic logic [2:0] access_len(input logic [1:0] sel);
        case (sel)
            2'd0:    access_len = 3'd1;
            2'd1:    access_len = 3'd2;
            default: access_len = 3'd4;
        endcase
    endfunction

    // Little-endian byte extraction: byte k lives in bits [8k+7:8k].
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    get_byte = word[7:0];
            2'd1:    get_byte = word[15:8];
            2'd2:    get_byte = word[23:16];
            default: get_byte = word[31:24];
        endcase
    endfunction

    // Little-endian byte insertion into an assembled word.
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        put_byte = word;
        case (idx)
            2'd0:    put_byte[7:0]   = b;
            2'd1:    put_byte[15:8]  = b;
            2'd2:    put_byte[23:16] = b;
            default: put_byte[31:24] = b;
        endcase
    endfunction

    assign cnt_inc_s = cnt_r + 3'd1;
    assign cnt_dec_s = cnt_r - 3'd1;

    // Next-state, latched-request and next-cycle RAM port computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        own_mem_s   = own_mem_r;
        we_s        = we_r;
        len_s       = len_r;
        base_s      = base_r;
        wdata_s     = wdata_r;
        data_s      = data_r;
        ram_addr_s  = ram_addr;
        ram_we_s    = 1'b0;
        ram_wdata_s = ram_wdata;
        case (state_r)
            ST_IDLE: begin
                // MEM holds the older instruction, so it wins a tie.
                if (mem_req) begin
                    state_s     = ST_BUSY;
                    cnt_s       = 3'd0;
                    own_mem_s   = 1'b1;
                    we_s        = mem_we;
                    len_s       = access_len(mem_sel);
                    base_s      = mem_addr[RAM_AW-1:0];
                    wdata_s     = mem_wdata;
                    data_s      = 32'd0;
                    ram_addr_s  = mem_addr[RAM_AW-1:0];
                    ram_we_s    = mem_we;
                    ram_wdata_s = mem_we ? mem_wdata[7:0] : 8'd0;
                end else if (if_req && !if_cancel) begin
                    state_s     = ST_BUSY;
                    cnt_s       = 3'd0;
                    own_mem_s   = 1'b0;
                    we_s        = 1'b0;
                    len_s       = 3'd4;
                    base_s      = if_addr[RAM_AW-1:0];
                    wdata_s     = 32'd0;
                    data_s      = 32'd0;
                    ram_addr_s  = if_addr[RAM_AW-1:0];
                    ram_wdata_s = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_mem_r && if_cancel) begin
                    // Branch taken: the fetched word is no longer wanted.
                    state_s = ST_IDLE;
                end else if (we_r) begin
                    if (cnt_r == (len_r - 3'd1)) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s       = cnt_inc_s;
                        ram_we_s    = 1'b1;
                        ram_addr_s  = base_r + {{(RAM_AW-3){1'b0}}, cnt_inc_s};
                        ram_wdata_s = get_byte(wdata_r, cnt_inc_s[1:0]);
                    end
                end else begin
                    // Read data trails the address by one cycle.
                    if (cnt_r != 3'd0) begin
                        data_s = put_byte(data_r, cnt_dec_s[1:0], ram_rdata);
                    end else begin
                        data_s = data_r;
                    end
                    if (cnt_r == len_r) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s < len_r) begin
                            ram_addr_s = base_r + {{(RAM_AW-3){1'b0}}, cnt_inc_s};
                        end else begin
                            ram_addr_s = ram_addr;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches and registered RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            own_mem_r <= 1'b0;
            we_r      <= 1'b0;
            len_r     <= 3'd0;
            base_r    <= {RAM_AW{1'b0}};
            wdata_r   <= 32'd0;
            data_r    <= 32'd0;
            ram_addr  <= {RAM_AW{1'b0}};
            ram_we    <= 1'b0;
            ram_wdata <= 8'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            own_mem_r <= own_mem_s;
            we_r      <= we_s;
            len_r     <= len_s;
            base_r    <= base_s;
            wdata_r   <= wdata_s;
            data_r    <= data_s;
            ram_addr  <= ram_addr_s;
            ram_we    <= ram_we_s;
            ram_wdata <= ram_wdata_s;
        end
    end

    // A cancel arriving in the done cycle still suppresses the fetch pulse.
    assign done_phase_s = (state_r == ST_DONE);
    assign if_done      = done_phase_s & ~own_mem_r & ~if_cancel;
    assign mem_done     = done_phase_s & own_mem_r;
    assign if_data      = if_done  ? data_r : 32'd0;
    assign mem_rdata    = mem_done ? data_r : 32'd0;
    assign stallreq_if  = if_req  & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

    // Address bits above the RAM window are intentionally ignored.
    assign unused_s = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW], cnt_dec_s[2]};

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl: byte RAM with one-cycle read latency,
// transaction-level reference model (byte-addressed shadow memory, latency
// and byte-order rules), directed scenarios and randomized accesses.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam int RAM_AW = 17;
    localparam int RAM_SZ = 131072;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_cancel;
    logic [31:0]       if_data;
    logic              if_done;
    logic              stallreq_if;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              stallreq_mem;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    int n_chk = 0;
    int n_err = 0;
    int wr_count = 0;

    // Environment RAM (written only by the process below) and model memory.
    logic [7:0] ram      [0:RAM_SZ-1];
    bit         written  [0:RAM_SZ-1];
    logic [7:0] ref_mem  [0:RAM_SZ-1];
    bit         ref_wr   [0:RAM_SZ-1];
    logic              pl_en;
    logic [RAM_AW-1:0] pl_addr;
    logic [7:0]        pl_data;

    mem_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_data(if_data), .if_done(if_done), .stallreq_if(stallreq_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .stallreq_mem(stallreq_mem),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up content of a never-written byte.
    function automatic logic [7:0] init_byte(input logic [RAM_AW-1:0] a);
        logic [31:0] v;
        v = (32'(a) * 32'd37) ^ (32'(a) >> 7) ^ 32'h5A;
        return v[7:0];
    endfunction

    function automatic logic [7:0] ram_rd(input logic [RAM_AW-1:0] a);
        return written[a] ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [RAM_AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_byte(a);
    endfunction

    // Byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr]     <= pl_data;
            written[pl_addr] <= 1'b1;
        end else if (ram_we) begin
            ram[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
            wr_count          <= wr_count + 1;
        end
        ram_rdata <= ram_rd(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [7:0] d);
        ref_mem[a[RAM_AW-1:0]] = d;
        ref_wr[a[RAM_AW-1:0]]  = 1'b1;
    endtask

    // Little-endian read of n bytes from the model, address wrapping in the window.
    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = 32'd0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            r = r | (32'(ref_rd(a[RAM_AW-1:0])) << (8 * k));
        end
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a[RAM_AW-1:0];
        pl_data = d;
        ref_write(a, d);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_addr"},  32'(ram_addr), 32'd0);
        chk({tag, "_ram_we"},    32'(ram_we), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_if_done"},   32'(if_done), 32'd0);
        chk({tag, "_mem_done"},  32'(mem_done), 32'd0);
        chk({tag, "_if_data"},   if_data, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    endtask

    // One access from an idle controller, checked cycle by cycle.
    task automatic do_access(input logic is_if, input logic we, input logic [1:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd);
        int n;
        int exp_lat;
        int wr0;
        logic eff_we;
        logic seen;
        logic done_v;
        logic [31:0] exp_data;
        logic [31:0] a;
        logic [31:0] sh;
        eff_we   = !is_if && we;
        n        = is_if ? 4 : ((sel == 2'd0) ? 1 : ((sel == 2'd1) ? 2 : 4));
        exp_lat  = eff_we ? n + 1 : n + 2;
        exp_data = eff_we ? 32'd0 : model_read(addr, n);
        wr0      = wr_count;
        rd       = 32'd0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_sel   = sel;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        seen = 1'b0;
        for (int c = 1; c <= exp_lat && !seen; c++) begin
            @(negedge clk);
            a = addr + 32'(c - 1);
            if (c <= n) begin
                chk("ram_addr", 32'(ram_addr), 32'(a[RAM_AW-1:0]));
                if (eff_we) begin
                    sh = wdata >> (8 * (c - 1));
                    chk("ram_wdata", 32'(ram_wdata), 32'(sh[7:0]));
                end
            end
            chk("ram_we", 32'(ram_we), 32'(eff_we && (c <= n)));
            done_v = is_if ? if_done : mem_done;
            chk(is_if ? "if_done_cycle" : "mem_done_cycle", 32'(done_v), 32'(c == exp_lat));
            chk("stallreq", 32'(is_if ? stallreq_if : stallreq_mem), 32'(c != exp_lat));
            if (done_v) begin
                seen = 1'b1;
                rd   = is_if ? if_data : mem_rdata;
            end
            if (!is_if) if_cancel = 1'($urandom_range(0, 1));
        end
        if_cancel = 1'b0;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        if (seen && !eff_we) chk(is_if ? "if_data" : "mem_rdata", rd, exp_data);
        if (eff_we) begin
            for (int k = 0; k < n; k++) begin
                a  = addr + 32'(k);
                sh = wdata >> (8 * k);
                ref_write(a, sh[7:0]);
                chk("store_byte", 32'(ram_rd(a[RAM_AW-1:0])), 32'(ref_rd(a[RAM_AW-1:0])));
            end
        end
        chk("write_count", 32'(wr_count - wr0), eff_we ? 32'(n) : 32'd0);
        @(negedge clk);
        chk("single_pulse", 32'(if_done | mem_done), 32'd0);
        chk("no_late_write", 32'(wr_count - wr0), eff_we ? 32'(n) : 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic [31:0] addr;
        logic [RAM_AW-1:0] lo;
        int wr0;
        int mem_cyc;
        int if_cyc;
        int kind;
        logic [31:0] if_got;
        logic [31:0] mem_got;

        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_cancel = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        pl_en = 1'b0; pl_addr = '0; pl_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch of a known instruction word.
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h50); preload(32'h103, 8'h00);
        do_access(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, rd);
        chk("t1_fetch", rd, 32'h0050_0513);

        // Word store, then quiet RAM.
        do_access(1'b0, 1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF, rd);
        chk("t2_b0", 32'(ram_rd(17'h200)), 32'h0000_00EF);
        chk("t2_b3", 32'(ram_rd(17'h203)), 32'h0000_00DE);
        wr0 = wr_count;
        repeat (4) @(negedge clk);
        chk("t2_quiet", 32'(wr_count - wr0), 32'd0);

        // Simultaneous requests: MEM byte load first, then the fetch.
        preload(32'h10, 8'h80);
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'd0; mem_addr = 32'h10;
        mem_cyc = 0; if_cyc = 0; mem_got = 32'd0; if_got = 32'd0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 3) chk("t3_if_stalls", 32'(stallreq_if), 32'd1);
            if (mem_done) begin
                mem_cyc = c; mem_got = mem_rdata; mem_req = 1'b0;
            end
            if (if_done) begin
                if_cyc = c; if_got = if_data; if_req = 1'b0;
            end
        end
        chk("t3_mem_cycle", 32'(mem_cyc), 32'd3);
        chk("t3_mem_data", mem_got, 32'h0000_0080);
        chk("t3_if_cycle", 32'(if_cyc), 32'd10);
        chk("t3_if_data", if_got, model_read(32'h100, 4));

        // Fetch cancelled mid-flight; no done pulse afterwards.
        if_req = 1'b1; if_addr = 32'h300;
        repeat (3) @(negedge clk);
        if_cancel = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_cancel = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t4_no_done", 32'(if_done), 32'd0);
        end
        // Cancel in idle holds off the grant by one cycle.
        if_req = 1'b1; if_addr = 32'h200; if_cancel = 1'b1;
        @(negedge clk);
        if_cancel = 1'b0;
        do_access(1'b1, 1'b0, 2'd2, 32'h200, 32'd0, rd);
        chk("t4_refetch", rd, 32'hDEAD_BEEF);

        // Half-word load across the top of the RAM window.
        preload(32'h1FFFF, 8'hA5); preload(32'h0, 8'h3C);
        do_access(1'b0, 1'b0, 2'd1, 32'h0001_FFFF, 32'd0, rd);
        chk("t5_wrap", rd, 32'h0000_3CA5);

        // Reset in the middle of a word store.
        wr0 = wr_count;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'd2; mem_addr = 32'h400; mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t6_we_c1", 32'(ram_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        mem_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_writes", 32'(wr_count - wr0), 32'd1);
        ref_write(32'h400, 8'h0D);
        chk("t6_b0", 32'(ram_rd(17'h400)), 32'(ref_rd(17'h400)));
        chk("t6_b1", 32'(ram_rd(17'h401)), 32'(ref_rd(17'h401)));
        rst_n = 1'b1;
        @(negedge clk);
        do_access(1'b1, 1'b0, 2'd2, 32'h400, 32'd0, rd);

        // Randomized mix of fetches, loads and stores.
        for (int t = 0; t < 60; t++) begin
            r = $urandom;
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) lo = 17'h1FFFC + RAM_AW'($urandom_range(0, 3));
            else lo = RAM_AW'($urandom_range(0, RAM_SZ - 1));
            addr = {r[31:RAM_AW], lo};
            do_access(kind == 0, kind == 2, 2'($urandom_range(0, 3)), addr, $urandom, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
